// File: rtl/programmable_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : programmable_countdown_timer
//  Purpose  : Run-time programmable countdown timer for Morse symbol timing.
//             Supports one-shot/periodic mode, prescaler, pause, clear and
//             a sticky expiry flag. Optional macro TIMER_WRAP_COUNT_EN adds
//             a saturating 8-bit expiry counter output (wrap_count).
//  Revision : 1.0 - initial release
// ============================================================================
module programmable_countdown_timer #(
  parameter int WIDTH    = 27,
  parameter int PRESCALE = 1
) (
  input  logic             clk_100Mhz,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             pause,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             time_out,
  output logic             expired
`ifdef TIMER_WRAP_COUNT_EN
  ,
  output logic [7:0]       wrap_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Prescaler needs at least one bit even when every edge is a tick.
  localparam int              PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   C_PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO      = '0;

  state_t           r_state,    w_state;
  logic [WIDTH-1:0] r_count,    w_count;
  logic [WIDTH-1:0] r_reload,   w_reload;
  logic             r_periodic, w_periodic;
  logic [PW-1:0]    r_presc,    w_presc;
  logic             r_time_out, w_time_out;
  logic             r_expired,  w_expired;
  logic             r_running,  w_running;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_periodic <= 1'b0;
      r_presc    <= '0;
      r_time_out <= 1'b0;
      r_expired  <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_count    <= w_count;
      r_reload   <= w_reload;
      r_periodic <= w_periodic;
      r_presc    <= w_presc;
      r_time_out <= w_time_out;
      r_expired  <= w_expired;
      r_running  <= w_running;
    end
  end

  // Next-state logic, priority clear > start > pause > count.
  always_comb begin
    w_state    = r_state;
    w_count    = r_count;
    w_reload   = r_reload;
    w_periodic = r_periodic;
    w_presc    = r_presc;
    w_time_out = 1'b0;
    w_expired  = r_expired;

    if (clear) begin
      w_state   = S_IDLE;
      w_count   = C_ZERO;
      w_presc   = '0;
      w_expired = 1'b0;
    end else if (start) begin
      w_count    = load_value;
      w_reload   = load_value;
      w_periodic = periodic;
      w_presc    = '0;
      w_expired  = 1'b0;
      if (load_value == C_ZERO) begin
        // A zero load expires immediately and never enters RUN.
        w_state    = S_DONE;
        w_time_out = 1'b1;
        w_expired  = 1'b1;
      end else begin
        w_state = S_RUN;
      end
    end else if ((r_state == S_RUN) && !pause) begin
      if (r_presc == C_PRESC_LAST) begin
        w_presc = '0;
        if (r_count > C_ONE) begin
          w_count = r_count - C_ONE;
        end else begin
          w_time_out = 1'b1;
          w_expired  = 1'b1;
          if (r_periodic) begin
            w_count = r_reload;
          end else begin
            w_count = C_ZERO;
            w_state = S_DONE;
          end
        end
      end else begin
        w_presc = r_presc + PW'(1);
      end
    end

    w_running = (w_state == S_RUN);
  end

  assign count    = r_count;
  assign running  = r_running;
  assign time_out = r_time_out;
  assign expired  = r_expired;

`ifdef TIMER_WRAP_COUNT_EN
  logic [7:0] r_wrap;

  // Saturating expiry counter, updated on the same edge that raises time_out.
  always_ff @(posedge clk_100Mhz) begin
    if (reset || clear) begin
      r_wrap <= 8'd0;
    end else if (start) begin
      r_wrap <= (load_value == C_ZERO) ? 8'd1 : 8'd0;
    end else if (w_time_out && (r_wrap != 8'hFF)) begin
      r_wrap <= r_wrap + 8'd1;
    end
  end

  assign wrap_count = r_wrap;
`endif

endmodule
`default_nettype wire

// File: doc/programmable_countdown_timer.md
Name: programmable_countdown_timer

Overview:
Runtime-programmable countdown timer for Morse symbol timing (dot/dash/gap windows) in the decoder datapath.
- Generalises the fixed-count timer: run-time load value, one-shot or periodic mode, prescaler, pause, clear, and a sticky expiry flag.
- Sits between the decoder FSM, which issues start/clear, and the symbol classifier, which consumes time_out and expired.

Parameters:
WIDTH, 27, bit width of load_value and count (covers 1 s at 100 MHz).
PRESCALE, 1, clk_100Mhz cycles per count decrement; legal range >= 1.

Ports:
clk_100Mhz  in  1  system clock, 100 MHz.
reset  in  1  synchronous, active-high reset.
start  in  1  load load_value and begin counting (single-cycle strobe).
load_value  in  WIDTH  initial/reload count, sampled only when start is high.
periodic  in  1  mode select, sampled with start: 0 = one-shot, 1 = auto-reload.
pause  in  1  level; while high, count and prescaler hold.
clear  in  1  abort: go idle, count to 0, clear expired.
count  out  WIDTH  current remaining count.
running  out  1  high while in RUN.
time_out  out  1  one-cycle pulse on each expiry.
expired  out  1  sticky; set on expiry, cleared by start, clear or reset.

Behaviour:
- All outputs are registered. On reset: state IDLE; count, running, time_out and expired = 0; prescaler = 0; reload register = 0; mode = one-shot.
- States:
  - IDLE: running = 0. start with load_value != 0 -> RUN.
  - RUN: running = 1. One-shot expiry -> DONE; periodic expiry stays in RUN.
  - DONE: running = 0, expired = 1. start -> RUN.
- Priority per edge: reset > clear > start > pause > count.
- Tick: the prescaler counts 0..PRESCALE-1 in RUN while pause = 0. A tick occurs on the edge where the prescaler equals PRESCALE-1; the prescaler wraps to 0 on that edge. With PRESCALE = 1, every RUN edge is a tick.
- On a tick:
  - If count > 1: count <= count-1.
  - If count == 1 (expiry): time_out <= 1 for exactly one cycle and expired <= 1.
    - One-shot: count <= 0, go to DONE.
    - Periodic: count <= reload register, stay in RUN.
- Latency: start sampled at edge E with load_value = L -> time_out high in the cycle after edge E + L*PRESCALE. Periodic mode then repeats every L*PRESCALE cycles.
- start at any state: count <= load_value, reload <= load_value, mode <= periodic, prescaler <= 0, expired <= 0, time_out <= 0. Restarting mid-run discards the old count without a pulse.
- start with load_value == 0: the timer does not enter RUN. It raises time_out for one cycle on the next edge, sets expired, and goes to DONE regardless of periodic.
- clear: state IDLE, count <= 0, prescaler <= 0, expired <= 0, time_out <= 0. If start and clear are high together, clear wins.
- pause: freezes count and prescaler, so no tick or time_out can occur; running stays 1. Deasserting pause resumes with no lost or extra ticks.
- pause in IDLE or DONE has no effect.
- Count arithmetic is unsigned WIDTH bits and never underflows; a value of 0 is only reached via one-shot expiry, clear, or reset.
- reset mid-run returns to the reset state with no time_out pulse.

Optional Feature:
Macro TIMER_WRAP_COUNT_EN.
- Defined:
  - Adds output wrap_count (8 bits, unsigned), which increments on every expiry in either mode and saturates at 255.
  - Cleared to 0 by reset, clear, or start.
  - Updates on the same edge as time_out.
- Undefined: the wrap_count port and its logic are absent; all other behaviour is identical.

Test Plan:
1. PRESCALE=1, reset then start with load_value=8, periodic=0 -> count steps 8..1; time_out pulses once in the cycle after edge start+8; count=0, running=0, expired=1 holds.
2. PRESCALE=1, start with load_value=5, periodic=1, run 20 cycles -> time_out pulses at cycles 5, 10, 15, 20 after start; count reloads to 5; running stays 1; wrap_count=4 when TIMER_WRAP_COUNT_EN is defined.
3. PRESCALE=3, start with load_value=4, periodic=0 -> count decrements every 3 cycles; time_out at start+12; hold pause high for 7 cycles at count=2 -> time_out moves to start+19.
4. Restart mid-run: start 8, then start 3 at count=5 -> no pulse from the first run; time_out 3 cycles after the second start; expired was cleared by the second start.
5. Same-edge events: start and clear together at count=4 -> IDLE, count=0, no time_out. Separately, start with load_value=0 -> single time_out pulse on the next edge, expired=1, running=0.
6. Reset mid-run at count=3 -> all outputs 0 on the next edge; no time_out; a subsequent start with 2 expires at start+2.
